axi_lite_sys_regs: RTL
======================

Name: axi_lite_sys_regs

Overview:
AXI4-Lite responder for the PS M_AXI master port, which the system currently ties off. It provides a small system register file: ID, scratch, 16-bit LED output, synchronized slide-switch input, and a free-running cycle counter. It sits in the system top between the PS M_AXI interface and the board LEDs and switches, all in the PS clock domain.

Parameters:
ADDR_WIDTH, 32, byte address width of AWADDR/ARADDR
ID_VALUE, 32'h5359_0001, constant returned by ID register
GPIO_WIDTH, 16, width of gpio_out / gpio_in (1..32)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous active-high reset
s_axi_awaddr  input  ADDR_WIDTH  write address
s_axi_awprot  input  3  ignored
s_axi_awvalid  input  1  write address valid
s_axi_awready  output  1  write address ready
s_axi_wdata  input  32  write data
s_axi_wstrb  input  4  byte strobes
s_axi_wvalid  input  1  write data valid
s_axi_wready  output  1  write data ready
s_axi_bresp  output  2  write response
s_axi_bvalid  output  1  write response valid
s_axi_bready  input  1  write response ready
s_axi_araddr  input  ADDR_WIDTH  read address
s_axi_arprot  input  3  ignored
s_axi_arvalid  input  1  read address valid
s_axi_arready  output  1  read address ready
s_axi_rdata  output  32  read data
s_axi_rresp  output  2  read response
s_axi_rvalid  output  1  read data valid
s_axi_rready  input  1  read data ready
gpio_out  output  GPIO_WIDTH  LED drive (GPIO_OUT register)
gpio_in  input  GPIO_WIDTH  asynchronous switch inputs

Behaviour:
- Reset (async assert, sync release): awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, gpio_out=0, scratch=0, counter=0, gpio_in sync flops=0.
- Register map (decode on addr[4:2]; addr[1:0] ignored; any set bit in addr[ADDR_WIDTH-1:5] is unmapped):
  0x00 ID, RO, ID_VALUE
  0x04 SCRATCH, RW, 32 bits
  0x08 GPIO_OUT, RW, low GPIO_WIDTH bits; upper bits read 0
  0x0C GPIO_IN, RO, gpio_in after 2-flop synchronizer, zero-extended
  0x10 COUNTER, RO, 32-bit free-running, +1 per clk, wraps 0xFFFFFFFF->0
  0x14 CTRL, WO, bit0=1 clears COUNTER (self-clearing); reads return 0
  0x18, 0x1C and unmapped: reserved
- Responses: OKAY (2'b00) for mapped addresses. Writes to RO registers are ignored and return OKAY. Reserved or unmapped addresses return SLVERR (2'b10); such writes have no effect and such reads return rdata=0.
- Write path, one outstanding transaction:
  - AW and W are accepted independently. awready drops after AW capture; wready drops after W capture.
  - When both are held, the write executes with per-byte wstrb, and bvalid rises the next cycle.
  - AW and W in the same cycle: bvalid one cycle after that edge.
  - bvalid and bresp hold until bready. On the B handshake, awready and wready return to 1 the following cycle.
  - bready high while bvalid=0 has no effect.
- Read path, one outstanding transaction:
  - arready=1 when no read is pending.
  - AR handshake at edge N: rdata and rresp registered, rvalid=1 after edge N, arready=0.
  - rdata, rresp and rvalid hold stable until rready. arready returns to 1 the cycle after the R handshake.
- Read and write channels are fully independent. A read and a write to the same register completing on the same edge: the read returns the old value.
- COUNTER clear and increment on the same edge: clear wins, so the counter is 0 the next cycle. A partial-strobe CTRL write without byte0 has no effect.
- GPIO_IN read latency: the input change is visible after 2 clk edges plus the read latency.
- Reset mid-transaction: all handshakes abort, outputs take reset values, and no register write occurs unless it executed before the reset.

Test Plan:
- After reset, read 0x00 -> rvalid one cycle after AR, rdata=0x5359_0001, rresp=00. Read 0x08 -> 0.
- Write 0x04=0xDEADBEEF with wstrb=4'b0101, W presented 3 cycles before AW -> bvalid one cycle after AW, bresp=00. Read 0x04 -> 0x00AD00EF.
- Write 0x08=0x0001_A5A5 -> gpio_out=16'hA5A5 the cycle after W/AW capture. Read 0x08 -> 0x0000_A5A5.
- Drive gpio_in=16'h00F0; read 0x0C -> 0x000000F0 (≥3 cycles after the change). Read 0x40 -> rresp=10, rdata=0. Write 0x00 -> bresp=00 and ID unchanged.
- Hold bready=0 for 5 cycles -> bvalid, bresp stable and awready=0 throughout. Hold rready=0 likewise -> rdata stable.
- Let COUNTER run, write CTRL=1 -> subsequent read returns a small value (< latency+2). Force counter to 0xFFFFFFFF -> wraps to 0. Assert reset while bvalid=1 -> bvalid=0 immediately and awready=1.

Source files
------------

// File: rtl/axi_lite_sys_regs.sv
`timescale 1ns/1ps
// AXI4-Lite system register block: ID, scratch, GPIO out/in, free-running cycle counter, control.
// One outstanding transaction per channel; the read and write channels are fully independent.
module axi_lite_sys_regs #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h5359_0001,
  parameter int          GPIO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in
);

  typedef enum logic [2:0] {
    REG_ID       = 3'd0,
    REG_SCRATCH  = 3'd1,
    REG_GPIO_OUT = 3'd2,
    REG_GPIO_IN  = 3'd3,
    REG_COUNTER  = 3'd4,
    REG_CTRL     = 3'd5,
    REG_RSVD_6   = 3'd6,
    REG_RSVD_7   = 3'd7
  } reg_sel_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

  // Write channel state
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;
  logic [3:0]            r_wr_strb;

  // Read channel state
  logic                  r_arready;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rdata;

  // Register file
  logic [31:0]           r_scratch;
  logic [GPIO_WIDTH-1:0] r_gpio_out;
  logic [GPIO_WIDTH-1:0] r_gpio_meta;
  logic [GPIO_WIDTH-1:0] r_gpio_sync;
  logic [31:0]           r_counter;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_wr_exec;
  logic                  w_wr_mapped;
  logic                  w_rd_mapped;
  reg_sel_e              w_wr_sel;
  reg_sel_e              w_rd_sel;
  logic [1:0]            w_wr_resp;
  logic                  w_scratch_we;
  logic                  w_gpio_we;
  logic                  w_cnt_clr;
  logic [31:0]           w_scratch_next;
  logic [GPIO_WIDTH-1:0] w_gpio_next;
  logic [31:0]           w_rd_data;
  logic [1:0]            w_rd_resp;
  logic                  w_unused;

  assign w_aw_hs   = s_axi_awvalid & r_awready;
  assign w_w_hs    = s_axi_wvalid & r_wready;
  assign w_b_hs    = r_bvalid & s_axi_bready;
  assign w_ar_hs   = s_axi_arvalid & r_arready;
  assign w_r_hs    = r_rvalid & s_axi_rready;

  // Both halves captured and no response outstanding: commit the write this cycle.
  assign w_wr_exec = ~r_awready & ~r_wready & ~r_bvalid;

  assign w_wr_sel    = reg_sel_e'(r_wr_addr[4:2]);
  assign w_rd_sel    = reg_sel_e'(s_axi_araddr[4:2]);
  assign w_wr_mapped = (r_wr_addr[ADDR_WIDTH-1:5] == '0) && (r_wr_addr[4:2] < 3'd6);
  assign w_rd_mapped = (s_axi_araddr[ADDR_WIDTH-1:5] == '0) && (s_axi_araddr[4:2] < 3'd6);
  assign w_wr_resp   = w_wr_mapped ? RESP_OKAY : RESP_SLVERR;

  assign w_scratch_next = apply_strb(r_scratch, r_wr_data, r_wr_strb);
  assign w_gpio_next    = GPIO_WIDTH'(apply_strb(32'(r_gpio_out), r_wr_data, r_wr_strb));

  assign w_unused = ^{s_axi_awprot, s_axi_arprot, r_wr_addr[1:0], s_axi_araddr[1:0]};

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_scratch_we = 1'b0;
    w_gpio_we    = 1'b0;
    w_cnt_clr    = 1'b0;
    if (w_wr_exec && w_wr_mapped) begin
      case (w_wr_sel)
        REG_SCRATCH:  w_scratch_we = 1'b1;
        REG_GPIO_OUT: w_gpio_we    = 1'b1;
        REG_CTRL:     w_cnt_clr    = r_wr_strb[0] & r_wr_data[0];
        default:      ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    if (!w_rd_mapped) begin
      w_rd_resp = RESP_SLVERR;
    end else begin
      case (w_rd_sel)
        REG_ID:       w_rd_data = ID_VALUE;
        REG_SCRATCH:  w_rd_data = r_scratch;
        REG_GPIO_OUT: w_rd_data = 32'(r_gpio_out);
        REG_GPIO_IN:  w_rd_data = 32'(r_gpio_sync);
        REG_COUNTER:  w_rd_data = r_counter;
        default:      w_rd_data = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awready <= 1'b0;
        r_wr_addr <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_wready  <= 1'b0;
        r_wr_data <= s_axi_wdata;
        r_wr_strb <= s_axi_wstrb;
      end
      if (w_wr_exec) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_resp;
      end else if (w_b_hs) begin
        r_bvalid  <= 1'b0;
        r_bresp   <= RESP_OKAY;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rresp   <= w_rd_resp;
        r_rdata   <= w_rd_data;
      end else if (w_r_hs) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scratch   <= '0;
      r_gpio_out  <= '0;
      r_gpio_meta <= '0;
      r_gpio_sync <= '0;
      r_counter   <= '0;
    end else begin
      r_gpio_meta <= gpio_in;
      r_gpio_sync <= r_gpio_meta;
      if (w_scratch_we) begin
        r_scratch <= w_scratch_next;
      end
      if (w_gpio_we) begin
        r_gpio_out <= w_gpio_next;
      end
      // A clear coinciding with the increment wins.
      if (w_cnt_clr) begin
        r_counter <= '0;
      end else begin
        r_counter <= r_counter + 32'd1;
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign gpio_out      = r_gpio_out;

endmodule
